// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 multi-cycle stage controller:
// instruction codes, status codes and the controller state encoding.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   typedef enum logic [1:0] {
      STAT_AOK = 2'd0,
      STAT_HLT = 2'd1,
      STAT_ADR = 2'd2,
      STAT_INS = 2'd3
   } stat_e;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_PCUPD     = 3'd6,
      S_HALT      = 3'd7
   } state_e;

endpackage

// File: rtl/y86_icode_class.sv
// Purely combinational classification of a Y86 icode into the properties
// the stage controller sequences on.
module y86_icode_class
   import y86_pkg::*;
(
   input  logic [3:0] icode,
   output logic       need_mem,
   output logic       mem_write,
   output logic       reg_write,
   output logic       sets_cc,
   output logic       valid
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      need_mem  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      sets_cc   = 1'b0;
      valid     = (icode <= I_POPQ);
      case (icode)
         I_RRMOVQ, I_IRMOVQ: reg_write = 1'b1;
         I_OPQ: begin
            reg_write = 1'b1;
            sets_cc   = 1'b1;
         end
         I_RMMOVQ: begin
            need_mem  = 1'b1;
            mem_write = 1'b1;
         end
         I_MRMOVQ, I_RET, I_POPQ: begin
            need_mem  = 1'b1;
            reg_write = 1'b1;
         end
         I_CALL, I_PUSHQ: begin
            need_mem  = 1'b1;
            mem_write = 1'b1;
            reg_write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/y86_stage_ctrl.sv
// Sequential (non-pipelined) Y86 stage controller: walks one instruction at a
// time through fetch/decode/execute/memory/writeback/PC-update.
module y86_stage_ctrl
   import y86_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       icode,
   input  logic             fetch_ready,
   input  logic             mem_ready,
   input  logic             mem_err,
   output logic             fetch_req,
   output logic             decode_en,
   output logic             exec_en,
   output logic             cc_we,
   output logic             mem_req,
   output logic             mem_we,
   output logic             reg_we,
   output logic             pc_we,
   output logic             busy,
   output logic [1:0]       stat,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   state_e           state_q, state_d;
   stat_e            stat_q, stat_d;
   logic [3:0]       icode_q, icode_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic need_mem, mem_write, reg_write, sets_cc, valid;

   // Classification works on the latched icode so outputs stay Moore.
   y86_icode_class u_class (
      .icode     (icode_q),
      .need_mem  (need_mem),
      .mem_write (mem_write),
      .reg_write (reg_write),
      .sets_cc   (sets_cc),
      .valid     (valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      if (rst) begin
         state_q   <= S_IDLE;
         stat_q    <= STAT_AOK;
         icode_q   <= 4'h0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         stat_q    <= stat_d;
         icode_q   <= icode_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      stat_d    = stat_q;
      icode_d   = icode_q;
      retired_d = retired_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_FETCH;
         S_FETCH: begin
            if (fetch_ready) begin
               icode_d = icode;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (icode_q == I_HALT) begin
               state_d = S_HALT;
               stat_d  = STAT_HLT;
            end else if (!valid) begin
               state_d = S_HALT;
               stat_d  = STAT_INS;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            if (need_mem)       state_d = S_MEMORY;
            else if (reg_write) state_d = S_WRITEBACK;
            else                state_d = S_PCUPD;
         end
         S_MEMORY: begin
            // An address error wins over a completion in the same cycle.
            if (mem_err) begin
               state_d = S_HALT;
               stat_d  = STAT_ADR;
            end else if (mem_ready) begin
               state_d = reg_write ? S_WRITEBACK : S_PCUPD;
            end
         end
         S_WRITEBACK: state_d = S_PCUPD;
         S_PCUPD: begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
         end
         S_HALT: ;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      fetch_req = 1'b0;
      decode_en = 1'b0;
      exec_en   = 1'b0;
      cc_we     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      reg_we    = 1'b0;
      pc_we     = 1'b0;
      busy      = (state_q != S_IDLE) && (state_q != S_HALT);
      case (state_q)
         S_FETCH:     fetch_req = 1'b1;
         S_DECODE:    decode_en = 1'b1;
         S_EXECUTE: begin
            exec_en = 1'b1;
            cc_we   = sets_cc;
         end
         S_MEMORY: begin
            mem_req = 1'b1;
            mem_we  = mem_write;
         end
         S_WRITEBACK: reg_we = 1'b1;
         S_PCUPD:     pc_we  = 1'b1;
         default: ;
      endcase
   end

   assign state   = state_q;
   assign stat    = stat_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_y86_stage_ctrl.sv
// Bench for y86_stage_ctrl: per-cycle stimulus/expectation rows queued per
// scenario, plus a narrow-counter instance for retired-count wrap.
module tb_y86_stage_ctrl;

   localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2, ST_EXE = 3'd3;
   localparam logic [2:0] ST_MEM  = 3'd4, ST_WB    = 3'd5, ST_PC  = 3'd6, ST_HALT = 3'd7;

   typedef struct {
      logic       start, fr, mr, me;
      logic [3:0] ic;
   } stim_t;

   typedef struct {
      logic [2:0]  st;
      logic [7:0]  en;
      logic        busy;
      logic [1:0]  stat;
      logic [31:0] ret;
   } exp_t;

   stim_t stim_q[$];
   exp_t  exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1, start = 1'b0, fetch_ready = 1'b0, mem_ready = 1'b0, mem_err = 1'b0;
   logic [3:0]  icode = 4'h0;
   logic        fetch_req, decode_en, exec_en, cc_we, mem_req, mem_we, reg_we, pc_we, busy;
   logic [1:0]  stat;
   logic [2:0]  state;
   logic [31:0] retired;
   logic [7:0]  en_vec;

   logic        rst4 = 1'b1, start4 = 1'b0, fr4 = 1'b0;
   logic [3:0]  icode4 = 4'h0;
   logic        fetch_req4, decode_en4, exec_en4, cc_we4, mem_req4, mem_we4, reg_we4, pc_we4, busy4;
   logic [1:0]  stat4;
   logic [2:0]  state4;
   logic [3:0]  retired4;
   logic [7:0]  en4;

   always #5 clk = ~clk;

   assign en_vec = {fetch_req, decode_en, exec_en, cc_we, mem_req, mem_we, reg_we, pc_we};
   assign en4    = {fetch_req4, decode_en4, exec_en4, cc_we4, mem_req4, mem_we4, reg_we4, pc_we4};

   y86_stage_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .icode(icode), .fetch_ready(fetch_ready),
      .mem_ready(mem_ready), .mem_err(mem_err),
      .fetch_req(fetch_req), .decode_en(decode_en), .exec_en(exec_en), .cc_we(cc_we),
      .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .pc_we(pc_we),
      .busy(busy), .stat(stat), .state(state), .retired(retired)
   );

   y86_stage_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst4), .start(start4), .icode(icode4), .fetch_ready(fr4),
      .mem_ready(1'b0), .mem_err(1'b0),
      .fetch_req(fetch_req4), .decode_en(decode_en4), .exec_en(exec_en4), .cc_we(cc_we4),
      .mem_req(mem_req4), .mem_we(mem_we4), .reg_we(reg_we4), .pc_we(pc_we4),
      .busy(busy4), .stat(stat4), .state(state4), .retired(retired4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_row(input logic st_i, input logic fr_i, input logic mr_i, input logic me_i,
                           input logic [3:0] ic_i, input logic [2:0] e_st, input logic [7:0] e_en,
                           input logic e_busy, input logic [1:0] e_stat, input logic [31:0] e_ret);
      stim_t s;
      exp_t  e;
      s.start = st_i; s.fr = fr_i; s.mr = mr_i; s.me = me_i; s.ic = ic_i;
      e.st = e_st; e.en = e_en; e.busy = e_busy; e.stat = e_stat; e.ret = e_ret;
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic drive(input stim_t s);
      start = s.start; fetch_ready = s.fr; mem_ready = s.mr; mem_err = s.me; icode = s.ic;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0; fetch_ready = 1'b0; mem_ready = 1'b0; mem_err = 1'b0; icode = 4'h0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({state, en_vec, busy, stat, retired} !== {ST_IDLE, 8'h00, 1'b0, 2'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL reset_async: got st=%0d en=%b busy=%b stat=%0d ret=%0d, want all zero",
                  state, en_vec, busy, stat, retired);
      end
      tick();
      n_checks++;
      if ({state, en_vec, busy} !== {ST_IDLE, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_held: got st=%0d en=%b busy=%b, want 0/0/0", state, en_vec, busy);
      end
   endtask

   task automatic test_nop();
      int row = 0;
      stim_t s;
      exp_t  e;
      do_reset();
      push_row(1, 1, 0, 0, 4'h1, ST_IDLE,  8'h00, 0, 0, 0);
      push_row(0, 1, 0, 0, 4'h1, ST_FETCH, 8'h80, 1, 0, 0);
      push_row(1, 0, 0, 1, 4'h1, ST_DEC,   8'h40, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h1, ST_EXE,   8'h20, 1, 0, 0);
      push_row(0, 0, 1, 0, 4'h1, ST_PC,    8'h01, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h1, ST_FETCH, 8'h80, 1, 0, 1);
      push_row(0, 0, 0, 0, 4'h1, ST_FETCH, 8'h80, 1, 0, 1);
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         drive(s);
         n_checks++;
         if ({state, en_vec, busy, stat, retired} !== {e.st, e.en, e.busy, e.stat, e.ret}) begin
            n_fail++;
            $display("FAIL nop row%0d: got st=%0d en=%b busy=%b stat=%0d ret=%0d, want st=%0d en=%b busy=%b stat=%0d ret=%0d",
                     row, state, en_vec, busy, stat, retired, e.st, e.en, e.busy, e.stat, e.ret);
         end
         row++;
         tick();
      end
   endtask

   task automatic test_mrmovq_wait();
      int row = 0;
      stim_t s;
      exp_t  e;
      do_reset();
      push_row(1, 1, 0, 0, 4'h5, ST_IDLE,  8'h00, 0, 0, 0);
      push_row(0, 1, 0, 0, 4'h5, ST_FETCH, 8'h80, 1, 0, 0);
      push_row(0, 0, 0, 1, 4'h0, ST_DEC,   8'h40, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h0, ST_EXE,   8'h20, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h0, ST_MEM,   8'h08, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h0, ST_MEM,   8'h08, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h0, ST_MEM,   8'h08, 1, 0, 0);
      push_row(0, 0, 1, 0, 4'h0, ST_MEM,   8'h08, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h0, ST_WB,    8'h02, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h0, ST_PC,    8'h01, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h0, ST_FETCH, 8'h80, 1, 0, 1);
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         drive(s);
         n_checks++;
         if ({state, en_vec, busy, stat, retired} !== {e.st, e.en, e.busy, e.stat, e.ret}) begin
            n_fail++;
            $display("FAIL mrmovq row%0d: got st=%0d en=%b busy=%b stat=%0d ret=%0d, want st=%0d en=%b busy=%b stat=%0d ret=%0d",
                     row, state, en_vec, busy, stat, retired, e.st, e.en, e.busy, e.stat, e.ret);
         end
         row++;
         tick();
      end
   endtask

   task automatic test_mem_err();
      int row = 0;
      stim_t s;
      exp_t  e;
      do_reset();
      push_row(1, 1, 0, 0, 4'h1, ST_IDLE,  8'h00, 0, 0, 0);
      push_row(0, 1, 0, 0, 4'h1, ST_FETCH, 8'h80, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h1, ST_DEC,   8'h40, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h1, ST_EXE,   8'h20, 1, 0, 0);
      push_row(0, 1, 0, 0, 4'h4, ST_PC,    8'h01, 1, 0, 0);
      push_row(0, 1, 0, 0, 4'h4, ST_FETCH, 8'h80, 1, 0, 1);
      push_row(0, 0, 0, 0, 4'h4, ST_DEC,   8'h40, 1, 0, 1);
      push_row(0, 0, 0, 0, 4'h4, ST_EXE,   8'h20, 1, 0, 1);
      push_row(0, 0, 1, 1, 4'h4, ST_MEM,   8'h0C, 1, 0, 1);
      push_row(1, 0, 1, 1, 4'h4, ST_HALT,  8'h00, 0, 2, 1);
      push_row(1, 1, 0, 0, 4'h1, ST_HALT,  8'h00, 0, 2, 1);
      push_row(0, 0, 0, 0, 4'h1, ST_HALT,  8'h00, 0, 2, 1);
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         drive(s);
         n_checks++;
         if ({state, en_vec, busy, stat, retired} !== {e.st, e.en, e.busy, e.stat, e.ret}) begin
            n_fail++;
            $display("FAIL mem_err row%0d: got st=%0d en=%b busy=%b stat=%0d ret=%0d, want st=%0d en=%b busy=%b stat=%0d ret=%0d",
                     row, state, en_vec, busy, stat, retired, e.st, e.en, e.busy, e.stat, e.ret);
         end
         row++;
         tick();
      end
   endtask

   task automatic test_halt();
      int row = 0;
      stim_t s;
      exp_t  e;
      do_reset();
      push_row(1, 1, 0, 0, 4'h0, ST_IDLE,  8'h00, 0, 0, 0);
      push_row(0, 1, 0, 0, 4'h0, ST_FETCH, 8'h80, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h0, ST_DEC,   8'h40, 1, 0, 0);
      push_row(1, 0, 0, 0, 4'h0, ST_HALT,  8'h00, 0, 1, 0);
      push_row(1, 1, 1, 0, 4'h1, ST_HALT,  8'h00, 0, 1, 0);
      push_row(0, 0, 0, 0, 4'h1, ST_HALT,  8'h00, 0, 1, 0);
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         drive(s);
         n_checks++;
         if ({state, en_vec, busy, stat, retired} !== {e.st, e.en, e.busy, e.stat, e.ret}) begin
            n_fail++;
            $display("FAIL halt row%0d: got st=%0d en=%b busy=%b stat=%0d ret=%0d, want st=%0d en=%b busy=%b stat=%0d ret=%0d",
                     row, state, en_vec, busy, stat, retired, e.st, e.en, e.busy, e.stat, e.ret);
         end
         row++;
         tick();
      end
   endtask

   task automatic test_ins();
      int row = 0;
      stim_t s;
      exp_t  e;
      do_reset();
      push_row(1, 1, 0, 0, 4'hC, ST_IDLE,  8'h00, 0, 0, 0);
      push_row(0, 1, 0, 0, 4'hC, ST_FETCH, 8'h80, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h1, ST_DEC,   8'h40, 1, 0, 0);
      push_row(1, 1, 0, 0, 4'h1, ST_HALT,  8'h00, 0, 3, 0);
      push_row(0, 0, 0, 0, 4'h1, ST_HALT,  8'h00, 0, 3, 0);
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         drive(s);
         n_checks++;
         if ({state, en_vec, busy, stat, retired} !== {e.st, e.en, e.busy, e.stat, e.ret}) begin
            n_fail++;
            $display("FAIL ins row%0d: got st=%0d en=%b busy=%b stat=%0d ret=%0d, want st=%0d en=%b busy=%b stat=%0d ret=%0d",
                     row, state, en_vec, busy, stat, retired, e.st, e.en, e.busy, e.stat, e.ret);
         end
         row++;
         tick();
      end
   endtask

   // OPq, pushq and rmmovq issued back to back with zero-wait memories.
   task automatic test_back_to_back();
      int row = 0;
      stim_t s;
      exp_t  e;
      do_reset();
      push_row(1, 1, 0, 0, 4'h6, ST_IDLE,  8'h00, 0, 0, 0);
      push_row(0, 1, 0, 0, 4'h6, ST_FETCH, 8'h80, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h6, ST_DEC,   8'h40, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h6, ST_EXE,   8'h30, 1, 0, 0);
      push_row(0, 0, 0, 0, 4'h6, ST_WB,    8'h02, 1, 0, 0);
      push_row(0, 1, 0, 0, 4'hA, ST_PC,    8'h01, 1, 0, 0);
      push_row(0, 1, 0, 0, 4'hA, ST_FETCH, 8'h80, 1, 0, 1);
      push_row(0, 0, 0, 0, 4'hA, ST_DEC,   8'h40, 1, 0, 1);
      push_row(0, 0, 0, 0, 4'hA, ST_EXE,   8'h20, 1, 0, 1);
      push_row(0, 0, 1, 0, 4'hA, ST_MEM,   8'h0C, 1, 0, 1);
      push_row(0, 0, 0, 0, 4'hA, ST_WB,    8'h02, 1, 0, 1);
      push_row(0, 1, 0, 0, 4'h4, ST_PC,    8'h01, 1, 0, 1);
      push_row(0, 1, 0, 0, 4'h4, ST_FETCH, 8'h80, 1, 0, 2);
      push_row(0, 0, 0, 0, 4'h4, ST_DEC,   8'h40, 1, 0, 2);
      push_row(0, 0, 0, 0, 4'h4, ST_EXE,   8'h20, 1, 0, 2);
      push_row(0, 0, 1, 0, 4'h4, ST_MEM,   8'h0C, 1, 0, 2);
      push_row(0, 0, 0, 0, 4'h4, ST_PC,    8'h01, 1, 0, 2);
      push_row(0, 0, 0, 0, 4'h4, ST_FETCH, 8'h80, 1, 0, 3);
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         drive(s);
         n_checks++;
         if ({state, en_vec, busy, stat, retired} !== {e.st, e.en, e.busy, e.stat, e.ret}) begin
            n_fail++;
            $display("FAIL b2b row%0d: got st=%0d en=%b busy=%b stat=%0d ret=%0d, want st=%0d en=%b busy=%b stat=%0d ret=%0d",
                     row, state, en_vec, busy, stat, retired, e.st, e.en, e.busy, e.stat, e.ret);
         end
         row++;
         tick();
      end
   endtask

   task automatic test_reset_mid_mem();
      do_reset();
      start = 1'b1; icode = 4'h5; fetch_ready = 1'b1;
      tick();
      start = 1'b0;
      tick();
      fetch_ready = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({state, mem_req} !== {ST_MEM, 1'b1}) begin
         n_fail++;
         $display("FAIL rst_mid_pre: got st=%0d mem_req=%b, want st=%0d mem_req=1", state, mem_req, ST_MEM);
      end
      #3 rst = 1'b1;
      #1;
      n_checks++;
      if ({state, en_vec, busy, stat, retired} !== {ST_IDLE, 8'h00, 1'b0, 2'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL rst_mid_async: got st=%0d en=%b busy=%b stat=%0d ret=%0d, want all zero",
                  state, en_vec, busy, stat, retired);
      end
      #1 rst = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({state, busy} !== {ST_IDLE, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_mid_idle: got st=%0d busy=%b, want st=0 busy=0", state, busy);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] ret_q[$];
      logic [3:0] want;
      int nops = 0;
      int cyc  = 0;
      n_checks++;
      if ({state4, en4, busy4, stat4, retired4} !== {ST_IDLE, 8'h00, 1'b0, 2'd0, 4'd0}) begin
         n_fail++;
         $display("FAIL wrap_reset: got st=%0d en=%b busy=%b stat=%0d ret=%0d, want all zero",
                  state4, en4, busy4, stat4, retired4);
      end
      rst4 = 1'b0; start4 = 1'b1; fr4 = 1'b1; icode4 = 4'h1;
      while ((nops < 16 || ret_q.size() != 0) && cyc < 200) begin
         tick();
         cyc++;
         if (ret_q.size() != 0) begin
            want = ret_q.pop_front();
            n_checks++;
            if (retired4 !== want) begin
               n_fail++;
               $display("FAIL wrap_count nop%0d: got retired=%0d, want %0d", nops, retired4, want);
            end
         end
         if (pc_we4) begin
            nops++;
            ret_q.push_back(4'(nops % 16));
         end
      end
      n_checks++;
      if (nops != 16 || retired4 !== 4'd0) begin
         n_fail++;
         $display("FAIL wrap_final: got nops=%0d retired=%0d after %0d cycles, want nops=16 retired=0",
                  nops, retired4, cyc);
      end
      rst4 = 1'b1; start4 = 1'b0; fr4 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_nop();
      test_mrmovq_wait();
      test_mem_err();
      test_halt();
      test_ins();
      test_back_to_back();
      test_reset_mid_mem();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/y86_stage_ctrl.md
Y86_STAGE_CTRL -- requirements
Module: y86_stage_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, setting the width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1: begins execution from IDLE.
REQ-005 The block SHALL have port icode, input, 4: instruction code from instruction memory, valid while fetch_ready=1.
REQ-006 The block SHALL have port fetch_ready, input, 1: instruction-memory response for fetch_req.
REQ-007 The block SHALL have ports mem_ready, input, 1 (data-memory completion) and mem_err, input, 1 (data-memory address error).
REQ-008 The block SHALL have stage-enable outputs, each 1 bit: fetch_req, decode_en, exec_en, cc_we, mem_req, mem_we, reg_we and pc_we.
REQ-009 The block SHALL have outputs busy (1), stat (2: 0 AOK, 1 HLT, 2 ADR, 3 INS), state (3) and retired (CNT_W).

Function
REQ-010 The FSM SHALL have states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD and HALT, with the 3-bit encoding shown on the state output.
REQ-011 IDLE: start=1 SHALL move to FETCH on the next edge; otherwise the FSM SHALL stay in IDLE.
REQ-012 FETCH: fetch_req SHALL be 1; on fetch_ready=1 the block SHALL latch icode and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-013 DECODE: decode_en SHALL be 1; latched icode 0x0 SHALL go to HALT with stat=HLT; icode above 0xB SHALL go to HALT with stat=INS; otherwise the FSM SHALL go to EXECUTE.
REQ-014 EXECUTE: exec_en SHALL be 1, and cc_we SHALL be 1 only for icode 0x6. The next state SHALL be MEMORY if the op needs memory (0x4, 0x5, 0x8, 0x9, 0xA, 0xB); otherwise WRITEBACK if it writes a register (0x2, 0x3, 0x6); otherwise PCUPD.
REQ-015 MEMORY: mem_req SHALL be held 1 until a completion is sampled; mem_we SHALL be 1 with it for icodes 0x4, 0x8 and 0xA.
REQ-016 In MEMORY, mem_err=1 SHALL go to HALT with stat=ADR and SHALL take priority over a simultaneous mem_ready=1.
REQ-017 In MEMORY, mem_ready=1 SHALL go to WRITEBACK if the op writes a register (0x5, 0x8, 0x9, 0xA, 0xB), otherwise to PCUPD.
REQ-018 WRITEBACK: reg_we SHALL be 1 for one cycle, then the FSM SHALL go to PCUPD.
REQ-019 PCUPD: pc_we SHALL be 1 for one cycle, retired SHALL increment by 1 (wrapping modulo 2^CNT_W), and the FSM SHALL go to FETCH.
REQ-020 HALT SHALL be sticky until rst, SHALL assert no stage enables, and halt/INS/ADR SHALL NOT increment retired.
REQ-021 All stage enables SHALL be decoded from the registered state (Moore), with no combinational path from any input to any output.
REQ-022 The block SHALL ignore fetch_ready, mem_ready and mem_err outside FETCH or MEMORY respectively, and SHALL ignore start outside IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE and HALT.
REQ-024 Minimum latency with zero-wait memories SHALL be 4 cycles for nop/jXX, 5 for rmmovq and 6 for mrmovq/OPq-free pushq/popq.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, stat=AOK, retired=0, the latched icode to 0 and all enables and busy to 0, including mid-MEMORY with mem_req high.
REQ-026 After rst deasserts, the FSM SHALL wait in IDLE for start.

Structure
REQ-027 Shared package y86_pkg SHALL hold the icode constants, the stat codes and the state enum.
REQ-028 One combinational sub-module, y86_icode_class, SHALL map icode to need_mem, mem_write, reg_write, sets_cc and valid.

Verification
REQ-029 The bench SHALL check this case: rst, then start with icode=0x1 and fetch_ready tied 1 -> state sequence FETCH, DECODE, EXECUTE, PCUPD, FETCH; pc_we high in cycle 4; retired=1.
REQ-030 The bench SHALL check this case: icode=0x5 with mem_ready delayed 3 cycles -> mem_req high for 4 cycles, mem_we=0, reg_we pulse, then pc_we; retired increments once.
REQ-031 The bench SHALL check this case: icode=0x4 with mem_err and mem_ready both 1 in the same cycle -> HALT, stat=2, retired unchanged, mem_req drops next cycle.
REQ-032 The bench SHALL check this case: icode=0x0 -> HALT with stat=1 and busy=0 that persists despite start pulses; icode=0xC -> stat=3.
REQ-033 The bench SHALL check this case: rst asserted mid-MEMORY -> outputs go to 0 with no clock edge, and state=IDLE.
REQ-034 The bench SHALL check this case: CNT_W=4 with 16 nops -> retired wraps 15 to 0.
